regfile_16x16: RTL and testbench

Sixteen-entry, 16-bit general-purpose register file for the six-instruction processor datapath. Write-back data arrives from the ALU/RAM write-back select, driven by the controller's write strobe. Two independent registered read ports (A, B) feed the ALU operands and the data-RAM store path. This block is the consumer of the write-back mux output and the producer of every operand the datapath reads.

---
 rtl/regfile_16x16.sv | 57 +++++
 tb/tb_regfile_16x16.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_16x16.sv
// Sixteen-entry register file with one write port and two registered read ports.
// Optional macro RF_BYPASS_EN forwards same-cycle write data to a colliding read.
module regfile_16x16 #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          W_wr,
  input  logic [AW-1:0] W_addr,
  input  logic [DW-1:0] W_data,
  input  logic          Ra_rd,
  input  logic [AW-1:0] Ra_addr,
  output logic [DW-1:0] Ra_data,
  input  logic          Rb_rd,
  input  logic [AW-1:0] Rb_addr,
  output logic [DW-1:0] Rb_data,
  output logic [7:0]    Wr_cnt
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_word_a;
  logic [DW-1:0] rd_word_b;

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  always_comb begin
    rd_word_a = mem[Ra_addr];
    rd_word_b = mem[Rb_addr];
`ifdef RF_BYPASS_EN
    // A read colliding with this cycle's write sees the incoming value.
    if (W_wr && (W_addr == Ra_addr)) rd_word_a = W_data;
    if (W_wr && (W_addr == Rb_addr)) rd_word_b = W_data;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      Ra_data <= '0;
      Rb_data <= '0;
      Wr_cnt  <= '0;
    end else begin
      if (W_wr) begin
        mem[W_addr] <= W_data;
        Wr_cnt      <= sat_inc(Wr_cnt);
      end
      if (Ra_rd) Ra_data <= rd_word_a;
      if (Rb_rd) Rb_data <= rd_word_b;
    end
  end

endmodule

// File: tb/tb_regfile_16x16.sv
// Randomized and directed bench for regfile_16x16 against an array-based reference model.
module tb_regfile_16x16;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        W_wr;
  logic [3:0]  W_addr;
  logic [15:0] W_data;
  logic        Ra_rd;
  logic [3:0]  Ra_addr;
  logic [15:0] Ra_data;
  logic        Rb_rd;
  logic [3:0]  Rb_addr;
  logic [15:0] Rb_data;
  logic [7:0]  Wr_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] m_mem [16];
  logic [15:0] m_ra, m_rb;
  int          m_cnt;

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  regfile_16x16 #(.DW(16), .AW(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .W_wr(W_wr), .W_addr(W_addr), .W_data(W_data),
    .Ra_rd(Ra_rd), .Ra_addr(Ra_addr), .Ra_data(Ra_data),
    .Rb_rd(Rb_rd), .Rb_addr(Rb_addr), .Rb_data(Rb_data),
    .Wr_cnt(Wr_cnt)
  );

  always #5 Clk = ~Clk;

  // Apply one cycle of stimulus, advance the model by the register-file rules,
  // and leave the outputs settled 1 time unit after the edge.
  task automatic step(input logic rst, input logic w, input logic [3:0] wa,
                      input logic [15:0] wd, input logic ra, input logic [3:0] raa,
                      input logic rb, input logic [3:0] rba);
    logic [15:0] va, vb;
    Reset = rst; W_wr = w; W_addr = wa; W_data = wd;
    Ra_rd = ra; Ra_addr = raa; Rb_rd = rb; Rb_addr = rba;
    @(posedge Clk);
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = 16'h0000;
      m_ra = 16'h0000; m_rb = 16'h0000; m_cnt = 0;
    end else begin
      va = (BYPASS && w && wa == raa) ? wd : m_mem[raa];
      vb = (BYPASS && w && wa == rba) ? wd : m_mem[rba];
      if (ra) m_ra = va;
      if (rb) m_rb = vb;
      if (w) begin
        m_mem[wa] = wd;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0);
    n_cmp++;
    if (Ra_data !== 16'h0 || Rb_data !== 16'h0 || Wr_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset_state: got Ra=%h Rb=%h cnt=%0d, want 0/0/0", Ra_data, Rb_data, Wr_cnt);
    end
    step(1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 1'b0, 4'd0);
    n_cmp++;
    if (Wr_cnt !== 8'd1) begin
      n_err++; $display("FAIL reset_precnt: got %0d, want 1", Wr_cnt);
    end
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 1'b0, 4'd0);
    n_cmp++;
    if (Ra_data !== 16'h0000 || Wr_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset_clear: got Ra=%h cnt=%0d, want 0000/0", Ra_data, Wr_cnt);
    end
  endtask

  task automatic test_basic();
    step(1'b0, 1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd10, 16'hABCD, 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 1'b1, 4'd10);
    n_cmp++;
    if (Ra_data !== 16'h1234) begin
      n_err++; $display("FAIL basic_a: got %h, want 1234", Ra_data);
    end
    n_cmp++;
    if (Rb_data !== 16'hABCD) begin
      n_err++; $display("FAIL basic_b: got %h, want abcd", Rb_data);
    end
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd10, 1'b1, 4'd10);
    n_cmp++;
    if (Ra_data !== 16'hABCD || Rb_data !== 16'hABCD) begin
      n_err++; $display("FAIL same_addr: got Ra=%h Rb=%h, want abcd", Ra_data, Rb_data);
    end
  endtask

  task automatic test_hold();
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd5, 16'h0001, 1'b0, 4'd5, 1'b0, 4'd0);
    n_cmp++;
    if (Ra_data !== 16'h1234) begin
      n_err++; $display("FAIL hold_1: got %h, want 1234", Ra_data);
    end
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd9, 1'b0, 4'd0);
    n_cmp++;
    if (Ra_data !== 16'h1234) begin
      n_err++; $display("FAIL hold_2: got %h, want 1234", Ra_data);
    end
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 1'b0, 4'd0);
    n_cmp++;
    if (Ra_data !== 16'h0001) begin
      n_err++; $display("FAIL hold_reread: got %h, want 0001", Ra_data);
    end
  endtask

  task automatic test_collision();
    logic [15:0] exp;
    exp = BYPASS ? 16'h2222 : 16'h1111;
    step(1'b0, 1'b1, 4'd7, 16'h1111, 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd7, 16'h2222, 1'b1, 4'd7, 1'b1, 4'd7);
    n_cmp++;
    if (Ra_data !== exp || Rb_data !== exp) begin
      n_err++;
      $display("FAIL collision: got Ra=%h Rb=%h, want %h", Ra_data, Rb_data, exp);
    end
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 1'b0, 4'd0);
    n_cmp++;
    if (Ra_data !== 16'h2222) begin
      n_err++; $display("FAIL collision_after: got %h, want 2222", Ra_data);
    end
  endtask

  task automatic test_reset_priority();
    step(1'b0, 1'b1, 4'd2, 16'h7777, 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'd2, 16'h5555, 1'b1, 4'd2, 1'b1, 4'd2);
    n_cmp++;
    if (Ra_data !== 16'h0 || Rb_data !== 16'h0 || Wr_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL rst_prio_edge: got Ra=%h Rb=%h cnt=%0d, want 0/0/0", Ra_data, Rb_data, Wr_cnt);
    end
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 1'b1, 4'd2);
    n_cmp++;
    if (Ra_data !== 16'h0000 || Rb_data !== 16'h0000 || Wr_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL rst_prio_read: got Ra=%h Rb=%h cnt=%0d, want 0/0/0", Ra_data, Rb_data, Wr_cnt);
    end
  endtask

  task automatic test_saturation();
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0);
    for (int i = 1; i <= 300; i++) begin
      step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 16'($urandom), 1'b0, 4'd0, 1'b0, 4'd0);
      if (i == 100 || i == 254 || i == 255 || i == 256 || i == 300) begin
        n_cmp++;
        if (Wr_cnt !== 8'((i > 255) ? 255 : i)) begin
          n_err++; $display("FAIL sat_cnt_%0d: got %0d, want %0d", i, Wr_cnt, (i > 255) ? 255 : i);
        end
      end
    end
    idle();
    n_cmp++;
    if (Wr_cnt !== 8'd255) begin
      n_err++; $display("FAIL sat_hold: got %0d, want 255", Wr_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)), 16'($urandom),
           $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
      n_cmp++;
      if (Ra_data !== m_ra || Rb_data !== m_rb || Wr_cnt !== 8'(m_cnt)) begin
        n_err++;
        $display("FAIL random_%0d: got Ra=%h Rb=%h cnt=%0d, want Ra=%h Rb=%h cnt=%0d",
                 i, Ra_data, Rb_data, Wr_cnt, m_ra, m_rb, m_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [16];
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      vals[i] = 16'($urandom);
      step(1'b0, 1'b1, 4'(i), vals[i], 1'b0, 4'd0, 1'b0, 4'd0);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'(i), 1'b1, 4'(15 - i));
      n_cmp++;
      if (Ra_data !== vals[i] || Rb_data !== vals[15 - i]) begin
        n_err++;
        $display("FAIL b2b_%0d: got Ra=%h Rb=%h, want Ra=%h Rb=%h",
                 i, Ra_data, Rb_data, vals[i], vals[15 - i]);
      end
    end
  endtask

  initial begin
    foreach (m_mem[i]) m_mem[i] = 16'h0;
    m_ra = 16'h0; m_rb = 16'h0; m_cnt = 0;
    Reset = 1'b1; W_wr = 1'b0; W_addr = 4'd0; W_data = 16'h0;
    Ra_rd = 1'b0; Ra_addr = 4'd0; Rb_rd = 1'b0; Rb_addr = 4'd0;
    test_reset();
    test_basic();
    test_hold();
    test_collision();
    test_reset_priority();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
